// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch and data ports onto one single-outstanding memory port with starvation guard and timeout.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic owner, lat_we, starve_full, ack, tmo, done, busy;
  logic [31:0] lat_addr, lat_wdata, rd;
  logic [3:0] lat_be;
  always_comb begin
    starve_full = starve_cnt == SW'(STARVE_MAX);
    dm_gnt = !reset && state == IDLE && dm_req && !(if_req && starve_full);
    if_gnt = !reset && state == IDLE && if_req && !dm_gnt;
    ack = !reset && state == WAIT && mem_ack;
    tmo = !reset && state == WAIT && !mem_ack && wait_cnt == WW'(TIMEOUT);
    done = ack || tmo;
    state_nxt = state == IDLE ? ((if_gnt || dm_gnt) ? ISSUE : IDLE) :
                state == ISSUE ? WAIT : ((state == WAIT && !done) ? WAIT : IDLE);
    busy = !reset && state != IDLE;
    mem_req = !reset && state == ISSUE;
    mem_we = busy && lat_we;
    mem_addr = busy ? lat_addr : '0;
    mem_wdata = busy ? lat_wdata : '0;
    mem_be = busy ? lat_be : '0;
    if_rvalid = done && !owner;
    dm_rvalid = done && owner;
    dm_err = tmo && owner;
    // stores complete with zero data; timeouts too
    rd = (ack && !lat_we) ? mem_rdata : '0;
    if_rdata = if_rvalid ? rd : '0;
    dm_rdata = dm_rvalid ? rd : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      starve_cnt <= '0;
      wait_cnt <= '0;
      owner <= 1'b0;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_be <= '0;
    end else begin
      state <= state_nxt;
      if (dm_gnt || if_gnt) begin
        owner <= dm_gnt;
        lat_we <= dm_gnt && dm_we;
        lat_addr <= dm_gnt ? dm_addr : if_addr;
        lat_wdata <= dm_gnt ? dm_wdata : '0;
        lat_be <= dm_gnt ? dm_be : 4'hF;
      end
      if (if_gnt) starve_cnt <= '0;
      else if (dm_gnt && if_req && !starve_full) starve_cnt <= starve_cnt + SW'(1);
      wait_cnt <= state == WAIT ? wait_cnt + WW'(1) : '0;
    end
  end
endmodule
